// File: rtl/mpmc11_pkg.sv
// Shared mpmc11 controller types plus the write-burst generator FSM encoding.
package mpmc11_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        ACTIVATE    = 4'd1,
        WRITE_CMD   = 4'd2,
        WRITE_DATA0 = 4'd3,
        WRITE_DATA1 = 4'd4,
        READ_CMD    = 4'd5,
        READ_DATA   = 4'd6,
        PRECHARGE   = 4'd7,
        REFRESH     = 4'd8
    } mpmc11_state_t;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_SEND = 2'd1,
        WB_FIN  = 2'd2
    } mpmc11_wr_burst_state_t;

    // Depth of the beat fifo; three entries cover the one-cycle buffer read latency.
    localparam int WB_FIFO_DEPTH = 3;

    // Modulo-3 pointer advance for the beat fifo.
    function automatic logic [1:0] wb_ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // The internal beat count reaches 256 for a full-length burst; the 8-bit
    // port saturates instead of wrapping back to 0.
    function automatic logic [7:0] wb_cnt_sat(input logic [8:0] c);
        return c[8] ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/mpmc11_wr_beat_fifo.sv
// 3-deep synchronous beat fifo. When empty, an incoming word is presented at
// the head in the same cycle so the first beat needs no extra cycle.
module mpmc11_wr_beat_fifo
    import mpmc11_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem [WB_FIFO_DEPTH];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic         empty;
    logic         store;
    logic         take;

    assign empty = (count == 2'd0);
    // A word pushed and popped in the same cycle while empty never lands in storage.
    assign store = push & ~(pop & empty);
    assign take  = pop & ~empty;
    assign valid = ~empty | push;
    assign dout  = empty ? din : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (store) wr_ptr <= wb_ptr_inc(wr_ptr);
            if (take)  rd_ptr <= wb_ptr_inc(rd_ptr);
            count <= count + {1'b0, store} - {1'b0, take};
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (store && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mpmc11_wr_burst_gen.sv
// Write-side burst generator: reads burst_len+1 beats from the port write
// buffer and streams them onto the app_wdf channel with last-beat and done flags.
module mpmc11_wr_burst_gen
    import mpmc11_pkg::*;
#(
    parameter int WID   = 256,
    parameter int MASKW = WID / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  mpmc11_state_t      state,
    input  logic [7:0]         burst_len,
    output logic               rd_en,
    output logic [7:0]         rd_addr,
    input  logic [WID-1:0]     rd_dat,
    input  logic [MASKW-1:0]   rd_sel,
    input  logic               app_wdf_rdy,
    output logic               app_wdf_wren,
    output logic               app_wdf_end,
    output logic [WID-1:0]     app_wdf_data,
    output logic [MASKW-1:0]   app_wdf_mask,
    output logic [7:0]         burst_cnt,
    output logic               done
);

    localparam int EW = WID + MASKW + 8;

    mpmc11_wr_burst_state_t fsm;
    mpmc11_wr_burst_state_t fsm_nxt;

    logic [7:0]       len_r;
    logic [8:0]       rd_ptr;
    logic             inflight;
    logic [7:0]       rd_idx_p1;
    logic [8:0]       cnt;
    logic             start;
    logic             clr;
    logic             pop;
    logic             fifo_valid;
    logic [1:0]       fifo_count;
    logic [EW-1:0]    head;
    logic [WID-1:0]   head_dat;
    logic [MASKW-1:0] head_sel;
    logic [7:0]       head_idx;

    assign start = (fsm == WB_IDLE) && (state == WRITE_DATA0);
    // Controller IDLE is an abort: everything in flight is dropped.
    assign clr   = start || (state == IDLE);
    assign pop   = app_wdf_wren & app_wdf_rdy;

    assign {head_dat, head_sel, head_idx} = head;

    assign rd_addr      = rd_ptr[7:0];
    assign burst_cnt    = wb_cnt_sat(cnt);
    assign app_wdf_data = app_wdf_wren ? head_dat : '0;
    assign app_wdf_mask = app_wdf_wren ? ~head_sel : '0;

    // Next-state and handshake outputs; credit check uses only registered state.
    always_comb begin
        fsm_nxt      = fsm;
        rd_en        = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        done         = 1'b0;
        case (fsm)
            WB_IDLE: begin
                if (start) fsm_nxt = WB_SEND;
            end
            WB_SEND: begin
                rd_en = (rd_ptr <= {1'b0, len_r}) &&
                        (({1'b0, fifo_count} + {2'b0, inflight}) < 3'd3);
                app_wdf_wren = fifo_valid;
                app_wdf_end  = fifo_valid && (head_idx == len_r);
                if (state == IDLE)
                    fsm_nxt = WB_IDLE;
                else if (app_wdf_wren && app_wdf_rdy && app_wdf_end)
                    fsm_nxt = WB_FIN;
            end
            WB_FIN: begin
                done    = 1'b1;
                fsm_nxt = WB_IDLE;
            end
            default: fsm_nxt = WB_IDLE;
        endcase
    end

    // FSM state, read pointer, in-flight flag and accepted-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= WB_IDLE;
            len_r    <= 8'd0;
            rd_ptr   <= 9'd0;
            inflight <= 1'b0;
            cnt      <= 9'd0;
        end else begin
            fsm <= fsm_nxt;
            if (start) len_r <= burst_len;
            if (clr) begin
                rd_ptr   <= 9'd0;
                inflight <= 1'b0;
                cnt      <= 9'd0;
            end else begin
                inflight <= rd_en;
                if (rd_en) rd_ptr <= rd_ptr + 9'd1;
                if (pop && (cnt < ({1'b0, len_r} + 9'd1))) cnt <= cnt + 9'd1;
            end
        end
    end

    // Beat index travels one cycle alongside the buffer read.
    always_ff @(posedge clk) begin
        if (rd_en) rd_idx_p1 <= rd_ptr[7:0];
    end

    mpmc11_wr_beat_fifo #(
        .W(EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr),
        .push  (inflight),
        .din   ({rd_dat, rd_sel, rd_idx_p1}),
        .pop   (pop),
        .dout  (head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

endmodule
